// File: rtl/rotate_right_seq.sv
// Iterative rotate-right unit: accepts an operand and amount, rotates one bit
// per clock, then holds the result until the consumer takes it.
module rotate_right_seq #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SW-1:0]    s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SW-1:0] CNT_ONE  = SW'(1);
  localparam logic [SW-1:0] CNT_ZERO = SW'(0);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] data_r;
  logic [SW-1:0]    cnt_r;

  function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] d);
    return {d[0], d[WIDTH-1:1]};
  endfunction

  // State register; reset wins over any handshake at the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and one-bit-per-cycle rotation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
      cnt_r  <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= A;
            cnt_r  <= s;
          end
        end
        BUSY: begin
          data_r <= ror1(data_r);
          cnt_r  <= cnt_r - CNT_ONE;
        end
        default: begin
          data_r <= data_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Next-state decode; a zero amount skips straight to DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = (s == CNT_ZERO) ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decode from the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign Out = data_r;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: vector table, scoreboard queue,
// hand-written stall and mid-operation reset sequences, random amount sweep.
module tb_rotate_right_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [3:0]  s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [3:0]  sh;
    logic [15:0] expv;
  } vec_t;
  vec_t vecs[6];

  rotate_right_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: rotate right by sh == rotate left by (16-sh) mod 16
  function automatic logic [15:0] rotl_model(input logic [15:0] a, input int k);
    logic [31:0] t;
    t = {a, a} << k;
    return t[31:16];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, expv);
    end
  endtask

  // Scoreboard: compare result on every completed output handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: actual=%h required=none", Out);
      end else begin
        check("out_data", Out, sb.pop_front());
      end
    end
  end

  // Called at posedge+1 right after the accepting edge; counts edges to out_valid
  task automatic wait_done(input int exp_lat);
    int edges = 0;
    int busy_cnt = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 40) begin
      checks++;
      failures++;
      $display("FAIL timeout_out_valid: actual=none required=latency %0d", exp_lat);
    end else begin
      check("latency", 16'(edges), 16'(exp_lat));
      check("busy_cycles", 16'(busy_cnt), 16'(exp_lat));
    end
  endtask

  // Full operation with out_ready high: accept, wait, drain, confirm return to IDLE
  task automatic do_op(input logic [15:0] a, input logic [3:0] sh, input logic [15:0] expv);
    check("in_ready_before", {15'd0, in_ready}, 16'd1);
    out_ready = 1'b1;
    A = a; s = sh; in_valid = 1'b1;
    sb.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'hDEAD; s = 4'd7;
    wait_done(int'(sh));
    @(posedge clk); #1;
    check("in_ready_after_drain", {14'd0, in_ready, out_valid}, 16'd2);
  endtask

  initial begin
    vecs[0] = '{a: 16'h8001, sh: 4'd1,  expv: 16'hC000};
    vecs[1] = '{a: 16'h1234, sh: 4'd4,  expv: 16'h4123};
    vecs[2] = '{a: 16'hABCD, sh: 4'd0,  expv: 16'hABCD};
    vecs[3] = '{a: 16'h00F0, sh: 4'd4,  expv: 16'h000F};
    vecs[4] = '{a: 16'h8000, sh: 4'd15, expv: 16'h0001};
    vecs[5] = '{a: 16'h0003, sh: 4'd2,  expv: 16'hC000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = 16'h0; s = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {12'd0, in_ready, out_valid, busy, 1'b0}, 16'h0008);
    check("reset_out", Out, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].sh, vecs[i].expv);
    end

    // Stalled DONE with in_valid held high throughout
    out_ready = 1'b0;
    A = 16'h0001; s = 4'd15; in_valid = 1'b1;
    sb.push_back(16'h0002);
    @(posedge clk); #1;
    A = 16'h00FF; s = 4'd4;
    wait_done(15);
    for (int i = 0; i < 5; i++) begin
      check("stall_out", Out, 16'h0002);
      check("stall_flags", {14'd0, in_ready, out_valid}, 16'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sb.push_back(16'hF00F);
    @(posedge clk); #1;
    check("stall_back_idle", {14'd0, in_ready, out_valid}, 16'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(4);
    @(posedge clk); #1;

    // Reset in the middle of a rotation discards the operation
    A = 16'hFFFF; s = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_out", Out, 16'h0000);
    check("midreset_flags", {13'd0, in_ready, out_valid, busy}, 16'd4);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid === 1'b1) seen++;
        @(posedge clk); #1;
      end
      check("no_out_valid_after_reset", 16'(seen), 16'd0);
    end
    do_op(16'h00F0, 4'd4, 16'h000F);

    // Random operand over every amount, checked against the rotate-left model
    for (int k = 0; k < 16; k++) begin
      logic [15:0] ra;
      ra = 16'($urandom);
      do_op(ra, 4'(k), rotl_model(ra, (16 - k) % 16));
    end

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_right_seq.md
# rotate_right_seq

Iterative 16-bit rotate-right unit for the phase-2 datapath. It handles the ROR and RORI shift-class operations, the opposite direction of the combinational rotate-left network. It accepts an operand and a 4-bit rotate amount over a valid/ready handshake and rotates right one bit per clock. It presents the result on a second valid/ready handshake and holds it until the consumer takes it.

## Interface
- WIDTH, 16, operand width; fixed at 16 for this design.
- SW, 4, width of rotate amount (log2 WIDTH).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand/amount presented.
- in_ready  output  1  unit can accept a new operation.
- A  input  16  operand to rotate.
- s  input  4  rotate-right amount, 0..15.
- out_valid  output  1  Out holds a completed result.
- out_ready  input  1  consumer takes result.
- Out  output  16  result register.
- busy  output  1  rotation in progress (BUSY state).

## Operation
- State machine has three states: IDLE, BUSY and DONE. It also holds a 16-bit data register and a 4-bit down-counter cnt.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&&in_ready: data<=A, cnt<=s.
  - Next state is DONE if s==0, otherwise BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle: data<={data[0],data[15:1]}, cnt<=cnt-1.
  - When cnt==1 at the edge, that rotation is the last one and the next state is DONE.
  - in_valid is ignored in this state.
- DONE:
  - out_valid=1, in_ready=0; Out and data are stable.
  - On out_valid&&out_ready, next state is IDLE.
  - No new operation is accepted in the same cycle as the drain. There is no bypass, so back-to-back operations have one idle cycle between them.
- Out is driven directly from the data register.
- Result equals rotate_right(A, s), which equals rotate_left(A, (16-s) mod 16). Bits are never lost or zero-filled.
- Handshake inputs are sampled only in their owning state. A and s are don't-care outside the accepting edge.
- out_ready held high continuously is legal: the result drains on the first DONE cycle.

## Timing
- The accepting edge is edge 0. out_valid is high after edge s, so latency equals s clock edges.
  - s=0: DONE and out_valid=1 immediately after the accepting edge.
  - s=15: 15 BUSY cycles.
- Throughput: one operation per s+2 cycles when out_ready is held high.
- in_ready, out_valid and busy decode purely from registered state; there are no combinational input-to-output paths.
- Reset (rst_n=0 at an edge, any state, including mid-BUSY or DONE):
  - Next state IDLE, data<=16'h0000, cnt<=0.
  - The in-flight operation is discarded and no out_valid is produced for it.
- After the reset edge: in_ready=1, out_valid=0, busy=0, Out=16'h0000.
- Reset has priority over both handshakes when they coincide at the same edge.

## Test plan
- A=16'h8001, s=1, out_ready=1 -> out_valid after edge 1, Out=16'hC000; in_ready returns to 1 the cycle after the drain.
- A=16'h1234, s=4 -> busy high for 4 cycles, out_valid after edge 4, Out=16'h4123.
- A=16'hABCD, s=0 -> out_valid the cycle after accept, Out=16'hABCD, busy never asserts.
- A=16'h0001, s=15, out_ready=0 for 5 DONE cycles with in_valid=1 throughout:
  - Out=16'h0002 stays stable and in_ready stays 0.
  - Only after out_ready=1 does the unit return to IDLE and accept the pending in_valid.
- A=16'hFFFF, s=8; assert rst_n=0 at edge 3 -> Out=16'h0000, out_valid never rises, in_ready=1 after the reset edge. A new op A=16'h00F0, s=4 then yields 16'h000F.
- Random sweep: all s in 0..15 over random A -> Out equals the rotate-left network's output for amount (16-s) mod 16, and latency is exactly s.
